mem_bus_ctrl: RTL and testbench

Sequencing controller between the FemtoRV32 memory port and the mapped slaves: SPI flash, SPI RAM and UART. Latches each CPU access, decodes the address region into a one-hot chip select, issues one-cycle read/write strobes and holds the CPU busy until the selected slave finishes. Captures read data into a registered return bus. Aborts hung or unmapped accesses with a sticky error and the offending address.

---
 rtl/femto_bus_pkg.sv | 30 +++
 rtl/mem_addr_decode.sv | 25 ++
 rtl/mem_bus_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/femto_bus_pkg.sv
// Shared definitions for the FemtoRV32 memory bus: region map, chip-select
// bit positions and the controller state encoding.
package femto_bus_pkg;

  localparam int unsigned NUM_CS = 7;

  localparam logic [15:0] REG_FLASH = 16'h0000;
  localparam logic [15:0] REG_RAM   = 16'h0001;
  localparam logic [15:0] REG_UART  = 16'h0040;
  localparam logic [15:0] REG_GPIO  = 16'h0041;
  localparam logic [15:0] REG_DIV   = 16'h0043;
  localparam logic [15:0] REG_BCD   = 16'h0044;

  // Bit 3 of the select vector is reserved and never driven.
  localparam int unsigned CS_FLASH = 0;
  localparam int unsigned CS_BCD   = 1;
  localparam int unsigned CS_DIV   = 2;
  localparam int unsigned CS_GPIO  = 4;
  localparam int unsigned CS_UART  = 5;
  localparam int unsigned CS_RAM   = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_WR_WAIT
  } bus_state_t;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational region decode of the upper address half into a one-hot
// slave select plus an unmapped flag.
module mem_addr_decode
  import femto_bus_pkg::*;
(
  input  logic [15:0]       region,
  output logic [NUM_CS-1:0] cs,
  output logic              unmapped
);

  always_comb begin
    cs = '0;
    case (region)
      REG_FLASH: cs[CS_FLASH] = 1'b1;
      REG_RAM:   cs[CS_RAM]   = 1'b1;
      REG_UART:  cs[CS_UART]  = 1'b1;
      REG_GPIO:  cs[CS_GPIO]  = 1'b1;
      REG_DIV:   cs[CS_DIV]   = 1'b1;
      REG_BCD:   cs[CS_BCD]   = 1'b1;
      default:   cs = '0;
    endcase
    unmapped = (cs == '0);
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequences one CPU access at a time onto the mapped slaves, stalls the CPU
// until the slave completes, and aborts unmapped or hung accesses.
module mem_bus_ctrl
  import femto_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wmask,
  input  logic              mem_rstrb,
  output logic [31:0]       mem_rdata,
  output logic              mem_rbusy,
  output logic              mem_wbusy,
  output logic [NUM_CS-1:0] slv_cs,
  output logic [31:0]       slv_addr,
  output logic [31:0]       slv_wdata,
  output logic [3:0]        slv_wmask,
  output logic              slv_rd,
  output logic              slv_wr,
  input  logic              flash_rbusy,
  input  logic              ram_rbusy,
  input  logic              ram_wbusy,
  input  logic [31:0]       flash_rdata,
  input  logic [31:0]       ram_rdata,
  input  logic [31:0]       uart_rdata,
  input  logic              err_clr,
  output logic              bus_err,
  output logic [31:0]       err_addr
);

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  bus_state_t        state_q, state_d;
  logic [15:0]       wait_cnt;
  logic              unmapped_q;
  logic [NUM_CS-1:0] dec_cs;
  logic              dec_unmapped;
  logic              accept_rd, accept_wr;
  logic              done, timeout, err_set;
  logic              rd_busy_sel, wr_busy_sel;
  logic [31:0]       rd_sel;

  mem_addr_decode u_decode (
    .region   (mem_addr[31:16]),
    .cs       (dec_cs),
    .unmapped (dec_unmapped)
  );

  assign rd_busy_sel = (slv_cs[CS_FLASH] & flash_rbusy) | (slv_cs[CS_RAM] & ram_rbusy);
  assign wr_busy_sel = slv_cs[CS_RAM] & ram_wbusy;

  always_comb begin
    rd_sel = '0;
    if (slv_cs[CS_FLASH])     rd_sel = flash_rdata;
    else if (slv_cs[CS_RAM])  rd_sel = ram_rdata;
    else if (slv_cs[CS_UART]) rd_sel = uart_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_wmask != '0) begin
          accept_wr = 1'b1;
          state_d   = ST_WR_ISSUE;
        end else if (mem_rstrb) begin
          accept_rd = 1'b1;
          state_d   = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (!rd_busy_sel) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_ISSUE: state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (!wr_busy_sel) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An unmapped access carries no busy, so it always terminates through done.
  assign err_set = (done & unmapped_q) | timeout;

  assign mem_rbusy = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT);
  assign mem_wbusy = (state_q == ST_WR_ISSUE) || (state_q == ST_WR_WAIT);
  assign slv_rd    = (state_q == ST_RD_ISSUE) && (slv_cs != '0);
  assign slv_wr    = (state_q == ST_WR_ISSUE) && (slv_cs != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      unmapped_q <= 1'b0;
      mem_rdata  <= '0;
      slv_cs     <= '0;
      slv_addr   <= '0;
      slv_wdata  <= '0;
      slv_wmask  <= '0;
      bus_err    <= 1'b0;
      err_addr   <= '0;
    end else begin
      if ((state_q == ST_RD_WAIT || state_q == ST_WR_WAIT) && state_d == state_q)
        wait_cnt <= wait_cnt + 16'd1;
      else
        wait_cnt <= '0;

      if (accept_rd || accept_wr) begin
        slv_addr   <= mem_addr;
        slv_cs     <= dec_cs;
        unmapped_q <= dec_unmapped;
        if (accept_wr) begin
          slv_wdata <= mem_wdata;
          slv_wmask <= mem_wmask;
        end
      end else if (state_q != ST_IDLE && state_d == ST_IDLE) begin
        slv_cs <= '0;
      end

      if (state_q == ST_RD_WAIT && (done || timeout))
        mem_rdata <= (timeout || unmapped_q) ? ERR_RDATA : rd_sel;

      if (err_set) begin
        bus_err <= 1'b1;
        if (!bus_err) err_addr <= slv_addr;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl; a second instance with a short timeout
// exercises the abort path.
module tb_mem_bus_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic        flash_rbusy, ram_rbusy, ram_wbusy;
  logic [31:0] flash_rdata, ram_rdata, uart_rdata;
  logic        err_clr;

  logic [31:0] mem_rdata, slv_addr, slv_wdata, err_addr;
  logic        mem_rbusy, mem_wbusy, slv_rd, slv_wr, bus_err;
  logic [6:0]  slv_cs;
  logic [3:0]  slv_wmask;

  logic [31:0] to_mem_rdata, to_slv_addr, to_slv_wdata, to_err_addr;
  logic        to_mem_rbusy, to_mem_wbusy, to_slv_rd, to_slv_wr, to_bus_err;
  logic [6:0]  to_slv_cs;
  logic [3:0]  to_slv_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .slv_cs(slv_cs),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_wmask(slv_wmask),
    .slv_rd(slv_rd), .slv_wr(slv_wr), .flash_rbusy(flash_rbusy),
    .ram_rbusy(ram_rbusy), .ram_wbusy(ram_wbusy), .flash_rdata(flash_rdata),
    .ram_rdata(ram_rdata), .uart_rdata(uart_rdata), .err_clr(err_clr),
    .bus_err(bus_err), .err_addr(err_addr)
  );

  mem_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(to_mem_rdata),
    .mem_rbusy(to_mem_rbusy), .mem_wbusy(to_mem_wbusy), .slv_cs(to_slv_cs),
    .slv_addr(to_slv_addr), .slv_wdata(to_slv_wdata), .slv_wmask(to_slv_wmask),
    .slv_rd(to_slv_rd), .slv_wr(to_slv_wr), .flash_rbusy(flash_rbusy),
    .ram_rbusy(ram_rbusy), .ram_wbusy(ram_wbusy), .flash_rdata(flash_rdata),
    .ram_rdata(ram_rdata), .uart_rdata(uart_rdata), .err_clr(err_clr),
    .bus_err(to_bus_err), .err_addr(to_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Outputs are sampled and inputs driven on the falling edge; each falling
  // edge is one cycle, cycle 0 being the one where the CPU strobe is driven.
  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic do_reset;
    cyc();
    rst = 1'b1;
    mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
    flash_rbusy = 1'b0; ram_rbusy = 1'b0; ram_wbusy = 1'b0;
    flash_rdata = '0; ram_rdata = '0; uart_rdata = '0; err_clr = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [174:0] all_out;
    do_reset();
    all_out = {mem_rdata, mem_rbusy, mem_wbusy, slv_cs, slv_addr, slv_wdata,
               slv_wmask, slv_rd, slv_wr, bus_err, err_addr};
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h exp 0", all_out);
    end
    n_checks++;
    if ({to_mem_rbusy, to_bus_err, to_mem_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_to_outputs: got %b %b %h exp 0", to_mem_rbusy, to_bus_err, to_mem_rdata);
    end
  endtask

  task automatic test_flash_read;
    int rd_cnt = 0;
    int done_at = -1;
    mem_addr = 32'h0000_0010; mem_rstrb = 1'b1; flash_rdata = 32'h1234_5678;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      mem_rstrb = 1'b0;
      if (slv_rd) rd_cnt++;
      if (!mem_rbusy && done_at < 0) done_at = c;
      if (c == 1) begin
        n_checks++;
        if (slv_cs !== 7'b0000001) begin
          n_fail++; $display("FAIL flash_cs: got %b exp 0000001", slv_cs);
        end
      end
      if (c == 8) begin
        n_checks++;
        if (mem_rdata !== 32'h1234_5678) begin
          n_fail++; $display("FAIL flash_rdata: got %h exp 12345678", mem_rdata);
        end
      end
      flash_rbusy = (c >= 2 && c <= 6);
    end
    n_checks++;
    if (rd_cnt !== 1) begin
      n_fail++; $display("FAIL flash_rd_pulses: got %0d exp 1", rd_cnt);
    end
    n_checks++;
    if (done_at !== 8) begin
      n_fail++; $display("FAIL flash_rbusy_low_cycle: got %0d exp 8", done_at);
    end
  endtask

  task automatic test_ram_write;
    int wr_cnt = 0;
    int done_at = -1;
    mem_addr = 32'h0001_0004; mem_wmask = 4'b0011; mem_wdata = 32'hCAFE_BABE;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      mem_wmask = '0;
      if (slv_wr) wr_cnt++;
      if (!mem_wbusy && done_at < 0) done_at = c;
      if (c == 1) begin
        n_checks++;
        if ({slv_cs, slv_wmask, slv_addr, slv_wdata} !== {7'b1000000, 4'b0011, 32'h0001_0004, 32'hCAFE_BABE}) begin
          n_fail++; $display("FAIL ram_write_latch: got cs=%b wm=%b a=%h d=%h exp cs=1000000 wm=0011 a=00010004 d=cafebabe",
                             slv_cs, slv_wmask, slv_addr, slv_wdata);
        end
      end
      ram_wbusy = (c >= 2 && c <= 4);
    end
    n_checks++;
    if (wr_cnt !== 1) begin
      n_fail++; $display("FAIL ram_wr_pulses: got %0d exp 1", wr_cnt);
    end
    n_checks++;
    if (done_at !== 6) begin
      n_fail++; $display("FAIL ram_wbusy_low_cycle: got %0d exp 6", done_at);
    end
  endtask

  task automatic test_back_to_back;
    mem_addr = 32'h0040_0000; mem_rstrb = 1'b1; uart_rdata = 32'h0000_0041;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      mem_rstrb = 1'b0;
      if (c == 1) begin
        n_checks++;
        if (slv_cs !== 7'b0100000 || slv_rd !== 1'b1) begin
          n_fail++; $display("FAIL uart_issue: got cs=%b rd=%b exp cs=0100000 rd=1", slv_cs, slv_rd);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (mem_rbusy !== 1'b0 || mem_rdata !== 32'h0000_0041) begin
          n_fail++; $display("FAIL uart_read: got busy=%b data=%h exp busy=0 data=00000041", mem_rbusy, mem_rdata);
        end
        mem_addr = 32'h0041_0000; mem_rstrb = 1'b1;
      end
      if (c == 4) begin
        n_checks++;
        if (mem_rbusy !== 1'b1 || slv_cs !== 7'b0010000) begin
          n_fail++; $display("FAIL b2b_accept: got busy=%b cs=%b exp busy=1 cs=0010000", mem_rbusy, slv_cs);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (mem_rbusy !== 1'b0 || mem_rdata !== 32'h0) begin
          n_fail++; $display("FAIL gpio_read: got busy=%b data=%h exp busy=0 data=00000000", mem_rbusy, mem_rdata);
        end
      end
    end
  endtask

  task automatic test_unmapped;
    int strobes = 0;
    do_reset();
    mem_addr = 32'h0050_0000; mem_rstrb = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      mem_rstrb = 1'b0; mem_wmask = '0;
      if (slv_rd || slv_wr) strobes++;
      if (c == 1) begin
        n_checks++;
        if (slv_cs !== 7'b0) begin
          n_fail++; $display("FAIL unmapped_cs: got %b exp 0000000", slv_cs);
        end
      end
      if (c == 3) begin
        n_checks++;
        if ({mem_rdata, bus_err, err_addr} !== {32'hFFFF_FFFF, 1'b1, 32'h0050_0000}) begin
          n_fail++; $display("FAIL unmapped_read: got data=%h err=%b addr=%h exp ffffffff 1 00500000", mem_rdata, bus_err, err_addr);
        end
        mem_addr = 32'h0070_0000; mem_wmask = 4'b0001;
      end
      if (c == 6) begin
        n_checks++;
        if ({mem_wbusy, bus_err, err_addr} !== {1'b0, 1'b1, 32'h0050_0000}) begin
          n_fail++; $display("FAIL second_error_keeps_addr: got wbusy=%b err=%b addr=%h exp 0 1 00500000", mem_wbusy, bus_err, err_addr);
        end
        err_clr = 1'b1;
      end
      if (c == 7) begin
        n_checks++;
        if (bus_err !== 1'b0 || err_addr !== 32'h0050_0000) begin
          n_fail++; $display("FAIL err_clr: got err=%b addr=%h exp 0 00500000", bus_err, err_addr);
        end
        mem_addr = 32'h0060_0000; mem_rstrb = 1'b1;
      end
      if (c == 10) begin
        n_checks++;
        if (bus_err !== 1'b1 || err_addr !== 32'h0060_0000) begin
          n_fail++; $display("FAIL error_beats_clr: got err=%b addr=%h exp 1 00600000", bus_err, err_addr);
        end
        err_clr = 1'b0;
      end
    end
    n_checks++;
    if (strobes !== 0) begin
      n_fail++; $display("FAIL unmapped_strobes: got %0d exp 0", strobes);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    mem_addr = 32'h0001_0000; mem_rstrb = 1'b1; ram_rbusy = 1'b1; ram_rdata = 32'h1111_2222;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      mem_rstrb = 1'b0;
      if (c == 5) begin
        n_checks++;
        if (to_mem_rbusy !== 1'b1 || to_bus_err !== 1'b0) begin
          n_fail++; $display("FAIL timeout_early: got busy=%b err=%b exp busy=1 err=0", to_mem_rbusy, to_bus_err);
        end
      end
      if (c == 6) begin
        n_checks++;
        if ({to_mem_rbusy, to_mem_rdata, to_bus_err, to_err_addr} !== {1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0001_0000}) begin
          n_fail++; $display("FAIL timeout_abort: got busy=%b data=%h err=%b addr=%h exp 0 ffffffff 1 00010000",
                             to_mem_rbusy, to_mem_rdata, to_bus_err, to_err_addr);
        end
        n_checks++;
        if (mem_rbusy !== 1'b1 || bus_err !== 1'b0) begin
          n_fail++; $display("FAIL long_timeout_still_waiting: got busy=%b err=%b exp busy=1 err=0", mem_rbusy, bus_err);
        end
      end
    end
    ram_rbusy = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_write_priority;
    int rd_cnt = 0;
    do_reset();
    mem_addr = 32'h0001_0000; mem_wmask = 4'hF; mem_rstrb = 1'b1;
    mem_wdata = 32'h0000_55AA; ram_rdata = 32'hDEAD_0001;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      mem_wmask = '0; mem_rstrb = 1'b0;
      if (slv_rd) rd_cnt++;
      if (c == 1) begin
        n_checks++;
        if ({slv_wr, mem_wbusy, mem_rbusy} !== 3'b110) begin
          n_fail++; $display("FAIL wr_priority_issue: got wr=%b wbusy=%b rbusy=%b exp 1 1 0", slv_wr, mem_wbusy, mem_rbusy);
        end
      end
      if (c == 3) begin
        n_checks++;
        if ({mem_wbusy, mem_rbusy, mem_rdata} !== {2'b00, 32'h0}) begin
          n_fail++; $display("FAIL wr_priority_done: got wbusy=%b rbusy=%b data=%h exp 0 0 00000000", mem_wbusy, mem_rbusy, mem_rdata);
        end
      end
    end
    n_checks++;
    if (rd_cnt !== 0) begin
      n_fail++; $display("FAIL wr_priority_rd_pulses: got %0d exp 0", rd_cnt);
    end
  endtask

  task automatic test_rst_mid_access;
    int rd_after = 0;
    logic [174:0] all_out;
    do_reset();
    mem_addr = 32'h0040_0000; mem_rstrb = 1'b1; uart_rdata = 32'h0000_0099;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      mem_rstrb = 1'b0;
      if (c >= 5 && slv_rd) rd_after++;
      if (c == 3) begin
        mem_addr = 32'h0000_0020; mem_rstrb = 1'b1;
      end
      if (c == 4) begin
        n_checks++;
        if ({slv_rd, mem_rdata} !== {1'b1, 32'h0000_0099}) begin
          n_fail++; $display("FAIL rst_pre_state: got rd=%b data=%h exp 1 00000099", slv_rd, mem_rdata);
        end
        flash_rbusy = 1'b1;
      end
      if (c == 6) rst = 1'b1;
      if (c == 7) begin
        all_out = {mem_rdata, mem_rbusy, mem_wbusy, slv_cs, slv_addr, slv_wdata,
                   slv_wmask, slv_rd, slv_wr, bus_err, err_addr};
        n_checks++;
        if (all_out !== '0) begin
          n_fail++; $display("FAIL rst_mid_access: got %h exp 0", all_out);
        end
        rst = 1'b0; flash_rbusy = 1'b0;
      end
    end
    n_checks++;
    if (rd_after !== 0) begin
      n_fail++; $display("FAIL rst_reissue: got %0d extra slv_rd exp 0", rd_after);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
    flash_rbusy = 1'b0; ram_rbusy = 1'b0; ram_wbusy = 1'b0;
    flash_rdata = '0; ram_rdata = '0; uart_rdata = '0; err_clr = 1'b0;
    test_reset();
    test_flash_read();
    test_ram_write();
    test_back_to_back();
    test_unmapped();
    test_timeout();
    test_write_priority();
    test_rst_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
